// File: rtl/matmul_core.sv
// Fixed-point 2x2 matrix-vector multiplier for Clarke/Park transforms and their inverses.
// One signed multiplier is shared over four cycles; the two row sums accumulate separately.
module matmul_core #(
  parameter int D_WIDTH = 19,
  parameter int Q_BITS  = 15
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [D_WIDTH-1:0] a_in,
  input  logic signed [D_WIDTH-1:0] b_in,
  input  logic signed [D_WIDTH-1:0] sin_in,
  input  logic signed [D_WIDTH-1:0] cos_in,
  input  logic                      start,
  input  logic [1:0]                op_in,
  output logic signed [D_WIDTH-1:0] a_out,
  output logic signed [D_WIDTH-1:0] b_out,
  output logic                      done
);

  localparam int CW = D_WIDTH + 1;      // coefficient width: holds -(-2^(D_WIDTH-1))
  localparam int AW = 2 * D_WIDTH + 1;  // product / accumulator width

  localparam logic signed [CW-1:0] K1  = CW'(32768);
  localparam logic signed [CW-1:0] K3  = CW'(18919);
  localparam logic signed [CW-1:0] K23 = CW'(37837);
  localparam logic signed [CW-1:0] KH  = -CW'(16384);
  localparam logic signed [CW-1:0] KS  = CW'(28378);

  localparam logic signed [AW-1:0] MAX_V = AW'((64'sd1 <<< (D_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MIN_V = -AW'(64'sd1 <<< (D_WIDTH - 1));

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [D_WIDTH-1:0] a_q, b_q, sin_q, cos_q;
  logic [1:0]                op_q;
  logic signed [AW-1:0]      acc0_q, acc0_d, acc1_q, acc1_d;
  logic signed [D_WIDTH-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic                      done_q, done_d;

  logic signed [CW-1:0] sin_x, cos_x, neg_sin, coef;
  logic signed [D_WIDTH-1:0] opnd;
  logic signed [AW-1:0] coef_w, opnd_w, prod, sh0, sh1;

  assign sin_x   = {sin_q[D_WIDTH-1], sin_q};
  assign cos_x   = {cos_q[D_WIDTH-1], cos_q};
  assign neg_sin = -sin_x;

  // Coefficient/operand select for the shared multiplier.
  always_comb begin
    coef = '0;
    opnd = a_q;
    unique case (state_q)
      MUL0: begin
        opnd = a_q;
        coef = op_q[1] ? cos_x : K1;
      end
      MUL1: begin
        opnd = b_q;
        unique case (op_q)
          2'd2:    coef = sin_x;
          2'd3:    coef = neg_sin;
          default: coef = '0;
        endcase
      end
      MUL2: begin
        opnd = a_q;
        unique case (op_q)
          2'd0:    coef = K3;
          2'd1:    coef = KH;
          2'd2:    coef = neg_sin;
          default: coef = sin_x;
        endcase
      end
      MUL3: begin
        opnd = b_q;
        unique case (op_q)
          2'd0:    coef = K23;
          2'd1:    coef = KS;
          default: coef = cos_x;
        endcase
      end
      default: ;
    endcase
  end

  assign coef_w = {{(AW-CW){coef[CW-1]}}, coef};
  assign opnd_w = {{(AW-D_WIDTH){opnd[D_WIDTH-1]}}, opnd};
  assign prod   = coef_w * opnd_w;
  assign sh0    = acc0_q >>> Q_BITS;
  assign sh1    = acc1_q >>> Q_BITS;

  always_comb begin
    state_d = state_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = MUL0;
      MUL0: begin acc0_d = prod;          state_d = MUL1; end
      MUL1: begin acc0_d = acc0_q + prod; state_d = MUL2; end
      MUL2: begin acc1_d = prod;          state_d = MUL3; end
      MUL3: begin acc1_d = acc1_q + prod; state_d = OUT;  end
      OUT: begin
        if (sh0 > MAX_V)      a_out_d = MAX_V[D_WIDTH-1:0];
        else if (sh0 < MIN_V) a_out_d = MIN_V[D_WIDTH-1:0];
        else                  a_out_d = sh0[D_WIDTH-1:0];
        if (sh1 > MAX_V)      b_out_d = MAX_V[D_WIDTH-1:0];
        else if (sh1 < MIN_V) b_out_d = MIN_V[D_WIDTH-1:0];
        else                  b_out_d = sh1[D_WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      op_q    <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      done_q  <= done_d;
      if (state_q == IDLE && start) begin
        a_q   <= a_in;
        b_q   <= b_in;
        sin_q <= sin_in;
        cos_q <= cos_in;
        op_q  <= op_in;
      end
    end
  end

  assign a_out = a_out_q;
  assign b_out = b_out_q;
  assign done  = done_q;

endmodule

// File: tb/tb_matmul_core.sv
// Directed bench for matmul_core: each transform, saturation, busy handling, abort and back-to-back.
`timescale 1ns/1ps
module tb_matmul_core;

  logic               clk = 1'b0;
  logic               rstb;
  logic signed [18:0] a_in, b_in, sin_in, cos_in;
  logic               start;
  logic [1:0]         op_in;
  logic signed [18:0] a_out, b_out;
  logic               done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matmul_core dut (
    .clk    (clk),
    .rstb   (rstb),
    .a_in   (a_in),
    .b_in   (b_in),
    .sin_in (sin_in),
    .cos_in (cos_in),
    .start  (start),
    .op_in  (op_in),
    .a_out  (a_out),
    .b_out  (b_out),
    .done   (done)
  );

  task automatic set_inputs(input int a, input int b, input int s, input int c, input int op);
    a_in   = 19'(a);
    b_in   = 19'(b);
    sin_in = 19'(s);
    cos_in = 19'(c);
    op_in  = 2'(op);
  endtask

  // Drives one start pulse from a falling edge; lat = cycles from start edge to done (-1 on timeout).
  task automatic run_op(input int a, input int b, input int s, input int c, input int op,
                        output int lat);
    set_inputs(a, b, s, c, op);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb  = 1'b1;
    start = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (a_out !== 19'sd0) begin errors++; $display("FAIL reset_a: got %0d expected 0", a_out); end
    checks++; if (b_out !== 19'sd0) begin errors++; $display("FAIL reset_b: got %0d expected 0", b_out); end
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL post_reset_done: got %b expected 0", done); end
    checks++; if (a_out !== 19'sd0) begin errors++; $display("FAIL post_reset_a: got %0d expected 0", a_out); end
    checks++; if (b_out !== 19'sd0) begin errors++; $display("FAIL post_reset_b: got %0d expected 0", b_out); end
    $display("reset: done=%b a_out=%0d b_out=%0d", done, a_out, b_out);
  endtask

  task automatic test_clarke();
    int lat;
    run_op(27427, 3310, 0, 0, 0, lat);
    $display("clarke: lat=%0d a_out=%0d b_out=%0d", lat, a_out, b_out);
    checks++; if (lat != 5) begin errors++; $display("FAIL clarke_latency: got %0d expected 5", lat); end
    checks++; if (a_out !== 19'(27427)) begin errors++; $display("FAIL clarke_a: got %0d expected 27427", a_out); end
    checks++; if (b_out !== 19'(19657)) begin errors++; $display("FAIL clarke_b: got %0d expected 19657", b_out); end
    set_inputs(1, 2, 3, 4, 3);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clarke_done_pulse: got %b expected 0", done); end
    checks++; if (a_out !== 19'(27427) || b_out !== 19'(19657)) begin
      errors++; $display("FAIL clarke_hold: got %0d/%0d expected 27427/19657", a_out, b_out);
    end
  endtask

  task automatic test_inv_clarke();
    int lat;
    run_op(-30376, 22970, 0, 0, 1, lat);
    $display("inv_clarke: lat=%0d a_out=%0d b_out=%0d", lat, a_out, b_out);
    checks++; if (a_out !== 19'(-30376)) begin errors++; $display("FAIL iclarke_a: got %0d expected -30376", a_out); end
    checks++; if (b_out !== 19'(35080)) begin errors++; $display("FAIL iclarke_b: got %0d expected 35080", b_out); end
  endtask

  task automatic test_park();
    int lat;
    run_op(-30376, 22970, 16384, 16384, 2, lat);
    $display("park: lat=%0d a_out=%0d b_out=%0d", lat, a_out, b_out);
    checks++; if (lat != 5) begin errors++; $display("FAIL park_latency: got %0d expected 5", lat); end
    checks++; if (a_out !== 19'(-3703)) begin errors++; $display("FAIL park_a: got %0d expected -3703", a_out); end
    checks++; if (b_out !== 19'(26673)) begin errors++; $display("FAIL park_b: got %0d expected 26673", b_out); end
  endtask

  task automatic test_inv_park();
    int lat;
    run_op(-30376, 22970, 16384, 16384, 3, lat);
    $display("inv_park: lat=%0d a_out=%0d b_out=%0d", lat, a_out, b_out);
    checks++; if (a_out !== 19'(-26673)) begin errors++; $display("FAIL ipark_a: got %0d expected -26673", a_out); end
    checks++; if (b_out !== 19'(-3703)) begin errors++; $display("FAIL ipark_b: got %0d expected -3703", b_out); end
  endtask

  task automatic test_saturation();
    int lat;
    run_op(262143, 262143, 0, 0, 0, lat);
    $display("sat_pos: a_out=%0d b_out=%0d", a_out, b_out);
    checks++; if (a_out !== 19'(262143)) begin errors++; $display("FAIL sat_pos_a: got %0d expected 262143", a_out); end
    checks++; if (b_out !== 19'(262143)) begin errors++; $display("FAIL sat_pos_b: got %0d expected 262143", b_out); end
    run_op(-262144, -262144, 0, 0, 0, lat);
    $display("sat_neg: a_out=%0d b_out=%0d", a_out, b_out);
    checks++; if (a_out !== 19'(-262144)) begin errors++; $display("FAIL sat_neg_a: got %0d expected -262144", a_out); end
    checks++; if (b_out !== 19'(-262144)) begin errors++; $display("FAIL sat_neg_b: got %0d expected -262144", b_out); end
    // -sin of the most negative value must not wrap: 262144*16384 >> 15 = 131072.
    run_op(0, 16384, -262144, 0, 3, lat);
    $display("neg_sin: a_out=%0d b_out=%0d", a_out, b_out);
    checks++; if (a_out !== 19'(131072)) begin errors++; $display("FAIL neg_sin_a: got %0d expected 131072", a_out); end
    checks++; if (b_out !== 19'sd0) begin errors++; $display("FAIL neg_sin_b: got %0d expected 0", b_out); end
    // Floor shift: -32768 >> 15 = -1, and -0.5 * -1 = 16384 >> 15 = 0.
    run_op(-1, 0, 0, 0, 1, lat);
    $display("floor: a_out=%0d b_out=%0d", a_out, b_out);
    checks++; if (a_out !== 19'(-1)) begin errors++; $display("FAIL floor_a: got %0d expected -1", a_out); end
    checks++; if (b_out !== 19'sd0) begin errors++; $display("FAIL floor_b: got %0d expected 0", b_out); end
  endtask

  task automatic test_busy();
    int ndone = 0;
    int lat = -1;
    logic signed [18:0] ra = '0, rb = '0;
    set_inputs(27427, 3310, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        set_inputs(-30376, 22970, 16384, 16384, 2);
        start = 1'b1;
      end else if (k == 2) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = k; ra = a_out; rb = b_out; end
      end
    end
    $display("busy: dones=%0d lat=%0d a_out=%0d b_out=%0d", ndone, lat, ra, rb);
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    checks++; if (lat != 5) begin errors++; $display("FAIL busy_latency: got %0d expected 5", lat); end
    checks++; if (ra !== 19'(27427) || rb !== 19'(19657)) begin
      errors++; $display("FAIL busy_result: got %0d/%0d expected 27427/19657", ra, rb);
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    int lat;
    set_inputs(-30376, 22970, 16384, 16384, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);   // state is MUL2 here
    rstb = 1'b1;
    @(negedge clk);
    checks++; if (a_out !== 19'sd0 || b_out !== 19'sd0) begin
      errors++; $display("FAIL abort_outputs: got %0d/%0d expected 0/0", a_out, b_out);
    end
    rstb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    $display("abort: dones=%0d a_out=%0d b_out=%0d", ndone, a_out, b_out);
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    checks++; if (a_out !== 19'sd0 || b_out !== 19'sd0) begin
      errors++; $display("FAIL abort_hold_zero: got %0d/%0d expected 0/0", a_out, b_out);
    end
    run_op(-30376, 22970, 16384, 16384, 2, lat);
    $display("abort_rerun: lat=%0d a_out=%0d b_out=%0d", lat, a_out, b_out);
    checks++; if (lat != 5) begin errors++; $display("FAIL rerun_latency: got %0d expected 5", lat); end
    checks++; if (a_out !== 19'(-3703) || b_out !== 19'(26673)) begin
      errors++; $display("FAIL rerun_result: got %0d/%0d expected -3703/26673", a_out, b_out);
    end
  endtask

  task automatic test_back_to_back();
    int k1 = -1, k2 = -1;
    logic signed [18:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    set_inputs(27427, 3310, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k1 >= 0 && k == k1 + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (k1 < 0) begin
          k1 = k; a1 = a_out; b1 = b_out;
          set_inputs(-30376, 22970, 0, 0, 1);
        end else begin
          k2 = k; a2 = a_out; b2 = b_out;
          break;
        end
      end
    end
    start = 1'b0;
    $display("b2b: first=%0d second=%0d r1=%0d/%0d r2=%0d/%0d", k1, k2, a1, b1, a2, b2);
    checks++; if (k1 != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", k1); end
    checks++; if (k2 - k1 != 6) begin errors++; $display("FAIL b2b_spacing: got %0d expected 6", k2 - k1); end
    checks++; if (a1 !== 19'(27427) || b1 !== 19'(19657)) begin
      errors++; $display("FAIL b2b_first_result: got %0d/%0d expected 27427/19657", a1, b1);
    end
    checks++; if (a2 !== 19'(-30376) || b2 !== 19'(35080)) begin
      errors++; $display("FAIL b2b_second_result: got %0d/%0d expected -30376/35080", a2, b2);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clarke();
    test_inv_clarke();
    test_park();
    test_inv_park();
    test_saturation();
    test_busy();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
